// File: rtl/sap_pkg.sv
// Shared opcodes, sequencer states and control-word layout for the SAP controller.
// Pure declarations: no logic, no latency, no flow control.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Encodings double as the externally visible tstate value.
    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_IDLE = 3'd5,
        S_HALT = 3'd6
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic pc_oe;
        logic pc_load;
        logic mar_we;
        logic ram_oe;
        logic ram_we;
        logic ir_we;
        logic ir_oe;
        logic a_we;
        logic a_oe;
        logic b_we;
        logic alu_oe;
        logic alu_sub;
        logic out_we;
    } ctrl_t;

endpackage

// File: rtl/sap_microdecode.sv
// Combinational microcode: (step, opcode, flags) -> control word and last-active-step flag.
// Zero latency; no flow control.
module sap_microdecode
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  state_e              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output ctrl_t               ctrl,
    output logic                last_step
);

    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        case (state)
            S_T0: begin
                ctrl.pc_oe  = 1'b1;
                ctrl.mar_we = 1'b1;
            end
            S_T1: begin
                ctrl.ram_oe = 1'b1;
                ctrl.ir_we  = 1'b1;
                ctrl.pc_en  = 1'b1;
            end
            S_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ir_oe  = 1'b1;
                        ctrl.mar_we = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.ir_oe = 1'b1;
                        ctrl.a_we  = 1'b1;
                        last_step  = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.ir_oe   = 1'b1;
                        ctrl.pc_load = 1'b1;
                        last_step    = 1'b1;
                    end
                    // A not-taken branch still drives the operand and still ends here.
                    OP_JC: begin
                        ctrl.ir_oe   = 1'b1;
                        ctrl.pc_load = carry_flag;
                        last_step    = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl.ir_oe   = 1'b1;
                        ctrl.pc_load = zero_flag;
                        last_step    = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl.a_oe   = 1'b1;
                        ctrl.out_we = 1'b1;
                        last_step   = 1'b1;
                    end
                    OP_HLT: ;
                    default: last_step = 1'b1;
                endcase
            end
            S_T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl.ram_oe = 1'b1;
                        ctrl.a_we   = 1'b1;
                        last_step   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.ram_oe  = 1'b1;
                        ctrl.b_we    = 1'b1;
                        ctrl.alu_sub = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        ctrl.a_oe   = 1'b1;
                        ctrl.ram_we = 1'b1;
                        last_step   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl.alu_oe  = 1'b1;
                    ctrl.a_we    = 1'b1;
                    ctrl.alu_sub = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 instruction sequencer: T-state register, carry/zero flags and control decode.
// Controls are combinational from the current step (zero latency); no backpressure, HLT stops until reset.
module sap_controller
    import sap_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int EARLY_END = 0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_carry,
    input  logic                alu_zero,
    output logic                pc_en,
    output logic                pc_oe,
    output logic                pc_load,
    output logic                mar_we,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                ir_we,
    output logic                ir_oe,
    output logic                a_we,
    output logic                a_oe,
    output logic                b_we,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                out_we,
    output logic                hlt,
    output logic                carry_flag,
    output logic                zero_flag,
    output logic [2:0]          tstate
);

    state_e state_q, state_d;
    logic   carry_q, carry_d;
    logic   zero_q,  zero_d;
    ctrl_t  ctrl;
    logic   last_step;

    sap_microdecode #(.OPCODE_W(OPCODE_W)) u_microdecode (
        .state      (state_q),
        .opcode     (opcode),
        .carry_flag (carry_q),
        .zero_flag  (zero_q),
        .ctrl       (ctrl),
        .last_step  (last_step)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                if (opcode == OP_HLT)
                    state_d = S_HALT;
                else if (EARLY_END != 0 && last_step)
                    state_d = S_T0;
                else
                    state_d = S_T3;
            end
            S_T3:   state_d = (EARLY_END != 0 && last_step) ? S_T0 : S_T4;
            S_T4: begin
                state_d = S_T0;
                // Flags only ever move at the end of an ADD/SUB writeback.
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    carry_d = alu_carry;
                    zero_d  = alu_zero;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_en      = ctrl.pc_en;
        pc_oe      = ctrl.pc_oe;
        pc_load    = ctrl.pc_load;
        mar_we     = ctrl.mar_we;
        ram_oe     = ctrl.ram_oe;
        ram_we     = ctrl.ram_we;
        ir_we      = ctrl.ir_we;
        ir_oe      = ctrl.ir_oe;
        a_we       = ctrl.a_we;
        a_oe       = ctrl.a_oe;
        b_we       = ctrl.b_we;
        alu_oe     = ctrl.alu_oe;
        alu_sub    = ctrl.alu_sub;
        out_we     = ctrl.out_we;
        hlt        = (state_q == S_HALT);
        carry_flag = carry_q;
        zero_flag  = zero_q;
        tstate     = state_q;
    end

endmodule

// File: tb/tb_sap_controller.sv
// Two controllers (fixed 5-step and early-end) run random programs against an instruction-level model.
module tb_sap_controller;

    localparam logic [13:0] PC_EN   = 14'h2000;
    localparam logic [13:0] PC_OE   = 14'h1000;
    localparam logic [13:0] PC_LOAD = 14'h0800;
    localparam logic [13:0] MAR_WE  = 14'h0400;
    localparam logic [13:0] RAM_OE  = 14'h0200;
    localparam logic [13:0] RAM_WE  = 14'h0100;
    localparam logic [13:0] IR_WE   = 14'h0080;
    localparam logic [13:0] IR_OE   = 14'h0040;
    localparam logic [13:0] A_WE    = 14'h0020;
    localparam logic [13:0] A_OE    = 14'h0010;
    localparam logic [13:0] B_WE    = 14'h0008;
    localparam logic [13:0] ALU_OE  = 14'h0004;
    localparam logic [13:0] ALU_SUB = 14'h0002;
    localparam logic [13:0] OUT_WE  = 14'h0001;
    localparam logic [13:0] BUS_DRV = PC_OE | RAM_OE | IR_OE | A_OE | ALU_OE;
    localparam int N_DIR = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] op_i [2];
    logic [1:0] alu_c_i, alu_z_i;
    logic [1:0] pc_en_o, pc_oe_o, pc_load_o, mar_we_o, ram_oe_o, ram_we_o, ir_we_o, ir_oe_o;
    logic [1:0] a_we_o, a_oe_o, b_we_o, alu_oe_o, alu_sub_o, out_we_o, hlt_o, cf_o, zf_o;
    logic [2:0] tst_o [2];

    always #5 clk = ~clk;

    sap_controller #(.OPCODE_W(4), .EARLY_END(0)) u_dut0 (
        .CLK(clk), .RESET(rst_n), .opcode(op_i[0]), .alu_carry(alu_c_i[0]), .alu_zero(alu_z_i[0]),
        .pc_en(pc_en_o[0]), .pc_oe(pc_oe_o[0]), .pc_load(pc_load_o[0]), .mar_we(mar_we_o[0]),
        .ram_oe(ram_oe_o[0]), .ram_we(ram_we_o[0]), .ir_we(ir_we_o[0]), .ir_oe(ir_oe_o[0]),
        .a_we(a_we_o[0]), .a_oe(a_oe_o[0]), .b_we(b_we_o[0]), .alu_oe(alu_oe_o[0]),
        .alu_sub(alu_sub_o[0]), .out_we(out_we_o[0]), .hlt(hlt_o[0]),
        .carry_flag(cf_o[0]), .zero_flag(zf_o[0]), .tstate(tst_o[0])
    );

    sap_controller #(.OPCODE_W(4), .EARLY_END(1)) u_dut1 (
        .CLK(clk), .RESET(rst_n), .opcode(op_i[1]), .alu_carry(alu_c_i[1]), .alu_zero(alu_z_i[1]),
        .pc_en(pc_en_o[1]), .pc_oe(pc_oe_o[1]), .pc_load(pc_load_o[1]), .mar_we(mar_we_o[1]),
        .ram_oe(ram_oe_o[1]), .ram_we(ram_we_o[1]), .ir_we(ir_we_o[1]), .ir_oe(ir_oe_o[1]),
        .a_we(a_we_o[1]), .a_oe(a_oe_o[1]), .b_we(b_we_o[1]), .alu_oe(alu_oe_o[1]),
        .alu_sub(alu_sub_o[1]), .out_we(out_we_o[1]), .hlt(hlt_o[1]),
        .carry_flag(cf_o[1]), .zero_flag(zf_o[1]), .tstate(tst_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: each instruction is a list of up to five control words.
    logic [13:0] ucode [16][5];
    logic [3:0]  d_op [N_DIR];
    logic        d_c [N_DIR];
    logic        d_z [N_DIR];

    int   m_phase [2];      // 0 idle, 1 running, 2 halted
    int   m_step [2];
    int   m_halt_cnt [2];
    logic m_c [2];
    logic m_z [2];
    bit   new_instr [2];
    bit   is_dir [2];
    int   dir_idx [2];
    logic dir_c [2];
    logic dir_z [2];
    bit   did_mid_add = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [13:0] obs_ctrl(int i);
        return {pc_en_o[i], pc_oe_o[i], pc_load_o[i], mar_we_o[i], ram_oe_o[i], ram_we_o[i],
                ir_we_o[i], ir_oe_o[i], a_we_o[i], a_oe_o[i], b_we_o[i], alu_oe_o[i],
                alu_sub_o[i], out_we_o[i]};
    endfunction

    function automatic logic [13:0] exp_word(int i, int s);
        logic [13:0] w;
        w = ucode[op_i[i]][s];
        if (s == 2 && ((op_i[i] == 4'h7 && !m_c[i]) || (op_i[i] == 4'h8 && !m_z[i])))
            w = w & ~PC_LOAD;
        return w;
    endfunction

    // Early-end length: through the last step that does anything, never shorter than T0..T2.
    function automatic int instr_len(int i);
        int last = 1;
        for (int s = 2; s < 5; s++)
            if (exp_word(i, s) != 14'h0) last = s;
        return (last < 2) ? 3 : last + 1;
    endfunction

    task automatic compare_all(input string pfx);
        for (int i = 0; i < 2; i++) begin
            logic [13:0] ew;
            logic [2:0]  et;
            ew = (m_phase[i] == 1) ? exp_word(i, m_step[i]) : 14'h0;
            et = (m_phase[i] == 0) ? 3'd5 : (m_phase[i] == 2) ? 3'd6 : 3'(m_step[i]);
            chk($sformatf("%s_d%0d_tstate", pfx, i), 32'(tst_o[i]), 32'(et));
            chk($sformatf("%s_d%0d_ctrl", pfx, i), 32'(obs_ctrl(i)), 32'(ew));
            chk($sformatf("%s_d%0d_hlt", pfx, i), 32'(hlt_o[i]), 32'(m_phase[i] == 2));
            chk($sformatf("%s_d%0d_carry", pfx, i), 32'(cf_o[i]), 32'(m_c[i]));
            chk($sformatf("%s_d%0d_zero", pfx, i), 32'(zf_o[i]), 32'(m_z[i]));
            chk($sformatf("%s_d%0d_onebus", pfx, i), 32'($countones(obs_ctrl(i) & BUS_DRV) <= 1), 32'd1);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_step[i] = 0; m_halt_cnt[i] = 0;
            m_c[i] = 1'b0; m_z[i] = 1'b0; new_instr[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input bit early);
        int last;
        if (m_phase[i] == 0) begin
            m_phase[i] = 1; m_step[i] = 0; new_instr[i] = 1'b1;
        end else if (m_phase[i] == 2) begin
            m_halt_cnt[i]++;
        end else if (m_step[i] == 2 && op_i[i] == 4'hF) begin
            m_phase[i] = 2; m_halt_cnt[i] = 0;
        end else begin
            last = early ? instr_len(i) - 1 : 4;
            if (m_step[i] == 4 && (op_i[i] == 4'h2 || op_i[i] == 4'h3)) begin
                m_c[i] = alu_c_i[i]; m_z[i] = alu_z_i[i];
            end
            if (m_step[i] == last) begin
                m_step[i] = 0; new_instr[i] = 1'b1;
            end else begin
                m_step[i]++;
            end
        end
    endtask

    function automatic logic [3:0] pick_op();
        int r = $urandom_range(0, 15);
        if (r == 15 && $urandom_range(0, 3) != 0) r = $urandom_range(0, 14);
        return 4'(r);
    endfunction

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (m_phase[i] == 2) begin
                op_i[i] = 4'($urandom_range(0, 15));
            end else if (new_instr[i]) begin
                new_instr[i] = 1'b0;
                if (dir_idx[i] < N_DIR) begin
                    op_i[i] = d_op[dir_idx[i]]; dir_c[i] = d_c[dir_idx[i]]; dir_z[i] = d_z[dir_idx[i]];
                    is_dir[i] = 1'b1; dir_idx[i]++;
                end else begin
                    op_i[i] = pick_op(); is_dir[i] = 1'b0;
                end
            end
            if (is_dir[i] && m_phase[i] == 1) begin
                alu_c_i[i] = dir_c[i]; alu_z_i[i] = dir_z[i];
            end else begin
                alu_c_i[i] = 1'($urandom_range(0, 1)); alu_z_i[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all("rst_async");
        @(posedge clk);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_dir(input int k, input logic [3:0] op, input logic c, input logic z);
        d_op[k] = op; d_c[k] = c; d_z[k] = z;
    endtask

    initial begin
        bit want_reset;
        for (int o = 0; o < 16; o++)
            for (int s = 0; s < 5; s++)
                ucode[o][s] = (s == 0) ? (PC_OE | MAR_WE) : (s == 1) ? (RAM_OE | IR_WE | PC_EN) : 14'h0;
        ucode[1][2] = IR_OE | MAR_WE;  ucode[1][3] = RAM_OE | A_WE;
        ucode[2][2] = IR_OE | MAR_WE;  ucode[2][3] = RAM_OE | B_WE;  ucode[2][4] = ALU_OE | A_WE;
        ucode[3][2] = IR_OE | MAR_WE;  ucode[3][3] = RAM_OE | B_WE | ALU_SUB;
        ucode[3][4] = ALU_OE | A_WE | ALU_SUB;
        ucode[4][2] = IR_OE | MAR_WE;  ucode[4][3] = A_OE | RAM_WE;
        ucode[5][2] = IR_OE | A_WE;
        ucode[6][2] = IR_OE | PC_LOAD;
        ucode[7][2] = IR_OE | PC_LOAD;
        ucode[8][2] = IR_OE | PC_LOAD;
        ucode[14][2] = A_OE | OUT_WE;

        set_dir(0, 4'h1, 0, 0);   set_dir(1, 4'h3, 1, 1);   set_dir(2, 4'h7, 0, 0);
        set_dir(3, 4'h8, 0, 0);   set_dir(4, 4'h2, 0, 0);   set_dir(5, 4'h8, 1, 1);
        set_dir(6, 4'h7, 1, 1);   set_dir(7, 4'h4, 0, 1);   set_dir(8, 4'h5, 1, 0);
        set_dir(9, 4'h6, 0, 0);   set_dir(10, 4'hE, 0, 0);  set_dir(11, 4'h0, 1, 1);
        set_dir(12, 4'hA, 0, 0);  set_dir(13, 4'h2, 1, 0);  set_dir(14, 4'hF, 0, 0);

        for (int i = 0; i < 2; i++) begin
            op_i[i] = 4'h0; dir_idx[i] = 0; is_dir[i] = 1'b0; dir_c[i] = 1'b0; dir_z[i] = 1'b0;
        end
        alu_c_i = 2'b00; alu_z_i = 2'b00;
        rst_n = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            compare_all("rst_hold");
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            compare_all("run");
            want_reset = 1'b0;
            if (m_phase[0] == 2 && m_phase[1] == 2 && m_halt_cnt[0] >= 20 && m_halt_cnt[1] >= 20)
                want_reset = 1'b1;
            if (m_halt_cnt[0] >= 60 || m_halt_cnt[1] >= 60)
                want_reset = 1'b1;
            if (!did_mid_add && dir_idx[0] >= N_DIR && m_phase[0] == 1 && m_step[0] == 3 &&
                (op_i[0] == 4'h2 || op_i[0] == 4'h3)) begin
                did_mid_add = 1'b1;
                want_reset  = 1'b1;
            end
            if ($urandom_range(0, 199) == 0)
                want_reset = 1'b1;
            if (want_reset) begin
                do_reset();
            end else begin
                @(posedge clk);
                model_edge(0, 1'b0);
                model_edge(1, 1'b1);
                #1 drive();
            end
        end
        chk("mid_add_reset_seen", 32'(did_mid_add), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Instruction sequencer for the 8-bit bus computer.
- Steps through fetch and execute T-states and decodes the 4-bit opcode from the instruction register.
- Drives the one-hot control signals of the program counter, MAR, RAM, IR, A/B registers, adder/subtractor and output register.
- Holds the carry/zero flag register used by conditional jumps, and stops the machine on HLT.

Parameters:
- OPCODE_W, 4, opcode width taken from IR high nibble.
- EARLY_END, 0: 0 = every instruction takes exactly 5 T-states; 1 = return to T0 immediately after an instruction's last active step.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  IR[7:4].
- alu_carry  in  1  adder/subtractor carry out.
- alu_zero  in  1  adder/subtractor result == 0.
- pc_en, pc_oe, pc_load  out  1 each  PC count enable / PC to bus / PC load from bus.
- mar_we  out  1  MAR load.
- ram_oe, ram_we  out  1 each  RAM to bus / RAM write.
- ir_we, ir_oe  out  1 each  IR load / IR low nibble to bus.
- a_we, a_oe  out  1 each  A load / A to bus.
- b_we  out  1  B load.
- alu_oe, alu_sub  out  1 each  ALU to bus / subtract select.
- out_we  out  1  output register load.
- hlt  out  1  machine halted.
- carry_flag, zero_flag  out  1 each  latched flags.
- tstate  out  3  current step: 0–4 = T0–T4, 5 = IDLE, 6 = HALT.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, HALT. State register, flags and all outputs are asynchronously cleared while RESET = 0. State = IDLE, all controls 0, hlt 0, flags 0.
- IDLE -> T0 on the first clock after reset release. No control is asserted in IDLE.
- Controls are a combinational decode of the state register, latched opcode input and flags. At most one bus driver (pc_oe, ram_oe, ir_oe, a_oe, alu_oe) is high in any state.
- Fetch, identical for all opcodes:
  - T0: pc_oe, mar_we.
  - T1: ram_oe, ir_we, pc_en.
- Execute by opcode (absent step = no controls):
  - 0000 NOP: none.
  - 0001 LDA: T2 ir_oe, mar_we; T3 ram_oe, a_we.
  - 0010 ADD: T2 ir_oe, mar_we; T3 ram_oe, b_we; T4 alu_oe, a_we, flag load.
  - 0011 SUB: as ADD, with alu_sub = 1 in T3 and T4.
  - 0100 STA: T2 ir_oe, mar_we; T3 a_oe, ram_we.
  - 0101 LDI: T2 ir_oe, a_we.
  - 0110 JMP: T2 ir_oe, pc_load.
  - 0111 JC: T2 ir_oe, pc_load only if carry_flag = 1.
  - 1000 JZ: T2 ir_oe, pc_load only if zero_flag = 1.
  - 1110 OUT: T2 a_oe, out_we.
  - 1111 HLT: T2 no controls; next state HALT.
  - 1001–1101 undefined: treated as NOP.
- Flag load: on the rising edge ending T4 of ADD/SUB, carry_flag <= alu_carry and zero_flag <= alu_zero. Flags are unchanged at all other times, including a not-taken JC/JZ.
- Sequencing, EARLY_END = 0: T0 -> T1 -> T2 -> T3 -> T4 -> T0. HLT goes T2 -> HALT.
- Sequencing, EARLY_END = 1: the last active step returns to T0.
  - LDA/STA end at T3; ADD/SUB end at T4.
  - LDI/JMP/JC/JZ/OUT/NOP/undefined end at T2, including a not-taken JC/JZ.
- HALT: all controls 0, hlt = 1, tstate = 6. Sticky until RESET = 0. Opcode and flag inputs are ignored.
- Reset mid-instruction: immediate return to IDLE with controls deasserted in the same cycle, with no partial writes after the reset assertion. The restart fetch begins at T0, one cycle after release.
- Opcode is sampled combinationally. IR only changes at the end of T1, so the opcode is stable during T2–T4.

Decomposition:
- Package sap_pkg holds:
  - the opcode localparams (OP_NOP … OP_HLT);
  - the state enum (S_IDLE, S_T0 … S_T4, S_HALT) with the tstate encodings above;
  - a packed control-word struct with one field per control output.
- Sub-module sap_microdecode is purely combinational: (state, opcode, carry_flag, zero_flag) -> control word plus a last_step flag.
- The top level keeps the state register, flag register and next-state logic.

Test Plan:
- Reset/IDLE: hold RESET = 0 for 3 clocks, then release. Required: all controls 0 while held; IDLE (tstate = 5) for 1 cycle, then T0 with pc_oe = mar_we = 1.
- Fetch + LDA, EARLY_END = 0: opcode = 0001. Required: T0 pc_oe/mar_we, T1 ram_oe/ir_we/pc_en, T2 ir_oe/mar_we, T3 ram_oe/a_we, T4 none, then T0. Period is 5 clocks.
- SUB flags: opcode = 0011, alu_carry = 1, alu_zero = 1 at T4. Required: alu_sub = 1 in T3–T4; carry_flag = zero_flag = 1 after T4. A following JC shows pc_load = 1 in T2.
- JZ not taken: zero_flag = 0, opcode = 1000. Required: T2 ir_oe = 1 and pc_load = 0, flags unchanged. With EARLY_END = 1 the next state after T2 is T0 (3-cycle instruction).
- HLT: opcode = 1111. Required: T2, then HALT with hlt = 1 and all controls 0 for 20 clocks regardless of opcode. RESET pulse returns to IDLE.
- Reset mid-ADD: assert RESET during T3. Required: b_we drops in the same cycle and flags clear to 0. After release the sequence runs IDLE -> T0.
